bf8b_fetch: RTL

- Instruction fetch stage of the bf8b core, sitting directly upstream of the decode stage.
- Owns the program counter and reads one 8-bit instruction per fetch from program memory over a valid handshake.
- Presents the instruction to decode with an enable/ready handshake, then waits for the execute stage to retire it.
- Applies branch redirects from execute before starting the next fetch.

---
 rtl/bf8b_fetch_if.sv | 34 +++
 rtl/bf8b_fetch.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bf8b_fetch_if.sv
// bf8b fetch stage bus bundle: program-memory read port, decode handshake,
// execute feedback (retire/branch/halt) and fetch status outputs.
interface bf8b_fetch_if #(
  parameter int AW = 6
) ();
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_data;
  logic          mem_valid;
  logic [7:0]    inst;
  logic          dec_en;
  logic          dec_ready;
  logic          exec_done;
  logic          branch_en;
  logic [AW-1:0] branch_addr;
  logic          halt;
  logic [AW-1:0] pc;
  logic          halted;
  logic          fault;

  // Fetch stage side.
  modport master (
    output mem_addr, mem_rd, inst, dec_en, pc, halted, fault,
    input  mem_data, mem_valid, dec_ready, exec_done, branch_en,
           branch_addr, halt
  );

  // Memory / decode / execute side.
  modport slave (
    input  mem_addr, mem_rd, inst, dec_en, pc, halted, fault,
    output mem_data, mem_valid, dec_ready, exec_done, branch_en,
           branch_addr, halt
  );
endinterface

// File: rtl/bf8b_fetch.sv
// bf8b instruction fetch stage. Owns the PC, reads one byte per fetch from
// program memory, hands it to decode, then waits for execute to retire it
// (optionally redirecting the PC on a branch). A halt request parks the stage
// in HALTED until reset.
// Optional feature: define FETCH_WATCHDOG_EN to add a memory-wait watchdog
// that raises a sticky fault and halts after TIMEOUT unanswered FETCH cycles.
module bf8b_fetch #(
  parameter int            AW       = 6,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}},
  parameter int            TIMEOUT  = 15
) (
  input logic         clk,
  input logic         rst_n,
  bf8b_fetch_if.master bus
);

  localparam logic [1:0] ST_FETCH     = 2'd0;
  localparam logic [1:0] ST_DISPATCH  = 2'd1;
  localparam logic [1:0] ST_WAIT_EXEC = 2'd2;
  localparam logic [1:0] ST_HALTED    = 2'd3;

  logic [1:0]    state_r;
  logic [AW-1:0] pc_r;
  logic [7:0]    inst_r;
  logic          mem_rd_r;
  logic          dec_en_r;
  logic          halted_r;
  logic          first_r;     // first DISPATCH cycle: dec_ready may be stale
  logic          fault_r;
  logic          wd_trip_s;   // watchdog expiry taken this cycle

`ifdef FETCH_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt_r;
  logic          wd_at_limit_s;

  assign wd_at_limit_s = (wd_cnt_r == CW'(TIMEOUT - 1));
  // halt and an arriving mem_valid both outrank the watchdog.
  assign wd_trip_s = (state_r == ST_FETCH) && !bus.halt && !bus.mem_valid &&
                     wd_at_limit_s;

  // Count consecutive unanswered FETCH cycles; zero outside FETCH so every
  // entry into FETCH starts a fresh window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_r <= {CW{1'b0}};
    end else if ((state_r != ST_FETCH) || bus.mem_valid) begin
      wd_cnt_r <= {CW{1'b0}};
    end else if (!wd_at_limit_s) begin
      wd_cnt_r <= wd_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_r <= 1'b0;
    end else if (wd_trip_s) begin
      fault_r <= 1'b1;
    end
  end
`else
  assign wd_trip_s = 1'b0;
  assign fault_r   = 1'b0;
`endif

  // Main fetch/dispatch/retire sequencer; halt overrides every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_FETCH;
      pc_r     <= RESET_PC;
      inst_r   <= 8'h00;
      mem_rd_r <= 1'b0;
      dec_en_r <= 1'b0;
      halted_r <= 1'b0;
      first_r  <= 1'b0;
    end else if (bus.halt && (state_r != ST_HALTED)) begin
      state_r  <= ST_HALTED;
      mem_rd_r <= 1'b0;
      dec_en_r <= 1'b0;
      halted_r <= 1'b1;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (bus.mem_valid) begin
            inst_r   <= bus.mem_data;
            pc_r     <= pc_r + {{(AW-1){1'b0}}, 1'b1};
            mem_rd_r <= 1'b0;
            dec_en_r <= 1'b1;
            first_r  <= 1'b1;
            state_r  <= ST_DISPATCH;
          end else if (wd_trip_s) begin
            mem_rd_r <= 1'b0;
            halted_r <= 1'b1;
            state_r  <= ST_HALTED;
          end else begin
            mem_rd_r <= 1'b1;
          end
        end
        ST_DISPATCH: begin
          if (first_r) begin
            first_r <= 1'b0;
          end else if (bus.dec_ready) begin
            dec_en_r <= 1'b0;
            state_r  <= ST_WAIT_EXEC;
          end
        end
        ST_WAIT_EXEC: begin
          if (bus.exec_done) begin
            if (bus.branch_en) begin
              pc_r <= bus.branch_addr;
            end
            mem_rd_r <= 1'b1;
            state_r  <= ST_FETCH;
          end
        end
        ST_HALTED: begin
          mem_rd_r <= 1'b0;
          dec_en_r <= 1'b0;
          halted_r <= 1'b1;
        end
        default: begin
          mem_rd_r <= 1'b0;
          dec_en_r <= 1'b0;
          halted_r <= 1'b1;
          state_r  <= ST_HALTED;
        end
      endcase
    end
  end

  assign bus.mem_addr = pc_r;
  assign bus.mem_rd   = mem_rd_r;
  assign bus.inst     = inst_r;
  assign bus.dec_en   = dec_en_r;
  assign bus.pc       = pc_r;
  assign bus.halted   = halted_r;
  assign bus.fault    = fault_r;

endmodule
